// File: rtl/mult_share_pkg.sv
// Shared constants and types for the shared-multiplier arbiter.
package mult_share_pkg;

  localparam int MS_WIDTH = 8;
  localparam int MS_NREQ  = 4;
  localparam int MS_IDW   = 2;

  // Response register occupancy.
  typedef enum logic {
    MS_EMPTY = 1'b0,
    MS_FULL  = 1'b1
  } ms_state_t;

  // A tagged response: owning requester and its product.
  typedef struct packed {
    logic [MS_IDW-1:0]     id;
    logic [2*MS_WIDTH-1:0] p;
  } ms_rsp_t;

endpackage

// File: rtl/mult_core.sv
// Purely combinational unsigned WIDTH x WIDTH -> 2*WIDTH multiplier built
// from shifted partial products summed in a single adder chain.
module mult_core #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic [2*WIDTH-1:0] p
);

  logic [2*WIDTH-1:0] pp [WIDTH];

  // One partial product per multiplier bit: a shifted into place when b[gi] is set.
  for (genvar gi = 0; gi < WIDTH; gi++) begin : g_pp
    assign pp[gi] = b[gi] ? ({{WIDTH{1'b0}}, a} << gi) : '0;
  end

  // Sum all partial products; 2*WIDTH bits holds the full result without overflow.
  always_comb begin
    p = '0;
    for (int i = 0; i < WIDTH; i++) begin
      p = p + pp[i];
    end
  end

endmodule

// File: rtl/mult_share_arbiter.sv
// Round-robin arbiter sharing one multiplier among NREQ requesters, with a
// single registered, tagged response port.
// Optional macro MULT_SHARE_PIPE_EN adds an operand stage ahead of the
// multiplier (latency 2, throughput unchanged).
module mult_share_arbiter
  import mult_share_pkg::*;
#(
  parameter int WIDTH = MS_WIDTH,
  parameter int NREQ  = MS_NREQ,
  parameter int IDW   = MS_IDW
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NREQ-1:0]       req_valid,
  output logic [NREQ-1:0]       req_ready,
  input  logic [NREQ*WIDTH-1:0] req_a,
  input  logic [NREQ*WIDTH-1:0] req_b,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [IDW-1:0]        rsp_id,
  output logic [2*WIDTH-1:0]    rsp_p,
  output logic                  busy
);

  localparam logic [IDW:0]   NREQ_V = (IDW+1)'(NREQ);
  localparam logic [IDW-1:0] LAST_ID = IDW'(NREQ - 1);

  // Rotate the valid vector so the pointer sits at bit 0, take the lowest set
  // bit, then rotate the offset back into an absolute requester index.
  // Returns {found, index}.
  function automatic logic [IDW:0] rr_pick(input logic [NREQ-1:0] vld,
                                           input logic [IDW-1:0]  ptr);
    logic [NREQ-1:0] rot;
    logic [IDW-1:0]  off;
    logic            found;
    logic [IDW:0]    sum;
    rot   = NREQ'({vld, vld} >> ptr);
    found = 1'b0;
    off   = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      if (rot[k]) begin
        found = 1'b1;
        off   = IDW'(k);
      end
    end
    sum = {1'b0, ptr} + {1'b0, off};
    if (sum >= NREQ_V) sum = sum - NREQ_V;
    return {found, sum[IDW-1:0]};
  endfunction

  ms_state_t          state_q, state_d;
  logic [IDW-1:0]     ptr_q, ptr_d;
  logic [IDW-1:0]     rsp_id_q, rsp_id_d;
  logic [2*WIDTH-1:0] rsp_p_q, rsp_p_d;

  logic               pick_found;
  logic [IDW-1:0]     pick_id;
  logic               can_accept;
  logic               grant;
  logic [WIDTH-1:0]   sel_a, sel_b;

  logic [WIDTH-1:0]   mul_a, mul_b;
  logic [IDW-1:0]     mul_id;
  logic               load_rsp;
  logic               busy_extra;
  logic [2*WIDTH-1:0] prod;

  // Pick a winner, qualify it with can_accept (and with reset released so no
  // requester sees ready while rst_n is low), and advance the pointer past it.
  always_comb begin
    {pick_found, pick_id} = rr_pick(req_valid, ptr_q);
    grant     = pick_found & can_accept & rst_n;
    req_ready = '0;
    ptr_d     = ptr_q;
    if (grant) begin
      req_ready[pick_id] = 1'b1;
      ptr_d = (pick_id == LAST_ID) ? '0 : pick_id + IDW'(1);
    end
  end

  assign sel_a = req_a[pick_id*WIDTH +: WIDTH];
  assign sel_b = req_b[pick_id*WIDTH +: WIDTH];

`ifdef MULT_SHARE_PIPE_EN
  logic               stg_valid_q, stg_valid_d;
  logic [WIDTH-1:0]   stg_a_q, stg_a_d;
  logic [WIDTH-1:0]   stg_b_q, stg_b_d;
  logic [IDW-1:0]     stg_id_q, stg_id_d;
  logic               stage_adv;

  // The stage moves forward whenever the response register can take it.
  assign stage_adv  = (state_q == MS_EMPTY) | rsp_ready;
  assign can_accept = ~stg_valid_q | stage_adv;
  assign mul_a      = stg_a_q;
  assign mul_b      = stg_b_q;
  assign mul_id     = stg_id_q;
  assign load_rsp   = stg_valid_q & stage_adv;
  assign busy_extra = stg_valid_q;

  // Operand stage: refill from the granted requester, or hold when stalled.
  always_comb begin
    stg_valid_d = stg_valid_q;
    stg_a_d     = stg_a_q;
    stg_b_d     = stg_b_q;
    stg_id_d    = stg_id_q;
    if (can_accept) begin
      stg_valid_d = grant;
      if (grant) begin
        stg_a_d  = sel_a;
        stg_b_d  = sel_b;
        stg_id_d = pick_id;
      end
    end
  end

  // Operand stage register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stg_valid_q <= 1'b0;
      stg_a_q     <= '0;
      stg_b_q     <= '0;
      stg_id_q    <= '0;
    end else begin
      stg_valid_q <= stg_valid_d;
      stg_a_q     <= stg_a_d;
      stg_b_q     <= stg_b_d;
      stg_id_q    <= stg_id_d;
    end
  end
`else
  // Operands go straight from the winning requester into the multiplier.
  assign can_accept = (state_q == MS_EMPTY) | rsp_ready;
  assign mul_a      = sel_a;
  assign mul_b      = sel_b;
  assign mul_id     = pick_id;
  assign load_rsp   = grant;
  assign busy_extra = 1'b0;
`endif

  mult_core #(.WIDTH(WIDTH)) u_mult_core (
    .a (mul_a),
    .b (mul_b),
    .p (prod)
  );

  // Response FSM: load a new product, drain to EMPTY, or hold stable.
  always_comb begin
    state_d  = state_q;
    rsp_id_d = rsp_id_q;
    rsp_p_d  = rsp_p_q;
    if (load_rsp) begin
      state_d  = MS_FULL;
      rsp_id_d = mul_id;
      rsp_p_d  = prod;
    end else if ((state_q == MS_FULL) && rsp_ready) begin
      state_d  = MS_EMPTY;
    end
  end

  // State, pointer and response registers; reset drops any held result.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= MS_EMPTY;
      ptr_q    <= '0;
      rsp_id_q <= '0;
      rsp_p_q  <= '0;
    end else begin
      state_q  <= state_d;
      ptr_q    <= ptr_d;
      rsp_id_q <= rsp_id_d;
      rsp_p_q  <= rsp_p_d;
    end
  end

  assign rsp_valid = (state_q == MS_FULL);
  assign rsp_id    = rsp_id_q;
  assign rsp_p     = rsp_p_q;
  assign busy      = (|req_valid) | rsp_valid | busy_extra;

endmodule
